ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Pipeline stage between EX and MEM/WB: latches the EX results and issues the data-cache request for the instruction in MEM.
- Holds the pipeline until the request completes, then captures the load data.
- Owns the LL/SC link register that backs atomic (datomic) accesses, including snoop invalidation.

Parameters:
WORD_W, 32, datapath / address width
REG_W, 5, register select width

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
ihit  in  1  pipeline advance enable from icache
flush  in  1  load bubble instead of EX inputs on next advance
dREN_in, dWEN_in, datomic_in  in  1 each  memory controls from EX
regWrite_in, MemtoReg_in, HALT_in  in  1 each  writeback controls from EX
wDataSrc_in  in  2  writeback source select
wsel_in  in  REG_W  destination register
aluout_in  in  WORD_W  ALU result / memory address
store_in  in  WORD_W  store data (forwarded rt)
pcp4_in  in  WORD_W  PC+4 for JAL
dhit  in  1  dcache request complete
dmemload  in  WORD_W  dcache read data
ccinv  in  1  coherence invalidate strobe
ccsnoopaddr  in  WORD_W  invalidated address
dmemREN, dmemWEN  out  1 each  dcache request
dmemaddr  out  WORD_W  = aluout_out
dmemstore  out  WORD_W  registered store data
mem_stall  out  1  MEM stage busy; upstream must hold
regWrite_out, MemtoReg_out, HALT_out  out  1 each  latched controls
wDataSrc_out  out  2  latched writeback source select
wsel_out  out  REG_W  latched destination register
aluout_out, pcp4_out  out  WORD_W each  latched values
memdata_out  out  WORD_W  load data, or SC result

Behaviour:
- Reset (async, nRST=0): every registered output = 0; done=0, link_valid=0, link_addr=0. dmemREN=dmemWEN=mem_stall=0.
- State bit `done`:
  - Set on dhit while a request is outstanding.
  - Cleared whenever the latch advances.
- SC gating: sc_fail = datomic_out & dWEN_out & ~(link_valid & link_addr==aluout_out).
- Memory request outputs (combinational from registers):
  - dmemREN = dREN_out & ~done.
  - dmemWEN = dWEN_out & ~done & ~sc_fail.
  - A failed SC issues no request.
- mem_stall = (dmemREN | dmemWEN) & ~dhit.
- Advance:
  - Latch loads when ihit & ~mem_stall.
  - flush=1 at advance loads a bubble: all fields 0, which makes it a NOP.
  - Otherwise the latch loads the *_in values.
  - No advance: all fields hold.
- Load data:
  - On dhit with dmemREN, memdata_out <= dmemload.
  - SC success: memdata_out <= 1 on dhit.
  - SC fail: memdata_out <= 0 in the first cycle the SC sits in MEM.
  - memdata_out otherwise holds until the next capture.
- Latency:
  - Non-memory instruction: 1 cycle in stage.
  - Memory instruction: 1 cycle plus dcache latency; dhit in the same cycle as the request means no stall.
- Link register:
  - LL (datomic & dREN) completing on dhit: link_valid<=1, link_addr<=aluout_out.
  - SC completing (success or fail): link_valid<=0.
  - Non-atomic store hitting link_addr on dhit: link_valid<=0.
  - ccinv & ccsnoopaddr==link_addr: link_valid<=0.
- Priority on simultaneous events in one cycle: LL set beats snoop clear; snoop clear beats SC success evaluation (SC fails).
- Request hold across ihit stalls: after dhit, done=1 suppresses re-issue while waiting for ihit.
- Reset mid-request drops the request immediately; the link is lost.
- HALT_out is latched like any control; the stage never blocks HALT.

Test Plan:
1. ADD bubble path: regWrite_in=1, wsel_in=5, aluout_in=0x10, ihit=1 -> next edge regWrite_out=1, wsel_out=5, aluout_out=0x10, mem_stall=0 throughout.
2. LW with 3-cycle dcache: dREN_in=1, addr 0x80 latched, dhit after 3 cycles with dmemload=0xDEADBEEF -> mem_stall=1 for 2 cycles, dmemREN deasserts after dhit, memdata_out=0xDEADBEEF, latch advances the next ihit.
3. dhit before ihit: SW completes while ihit=0 for 4 cycles -> dmemWEN pulses exactly one request, stays 0 until advance.
4. LL 0x100 then SC 0x100, no interference -> SC issues dmemWEN, memdata_out=1, link_valid=0 after.
5. LL 0x100, ccinv with ccsnoopaddr=0x100, then SC 0x100 -> dmemWEN never asserted, mem_stall=0, memdata_out=0.
6. flush=1 with ihit=1 and a pending SW in EX -> latched fields all 0, no dcache request; nRST pulsed mid-LW -> all outputs 0 asynchronously, link_valid=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline latch with dcache request, load capture and LL/SC link register.
module ex_mem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              flush,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              datomic_in,
  input  logic              regWrite_in,
  input  logic              MemtoReg_in,
  input  logic              HALT_in,
  input  logic [1:0]        wDataSrc_in,
  input  logic [REG_W-1:0]  wsel_in,
  input  logic [WORD_W-1:0] aluout_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic [WORD_W-1:0] pcp4_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              regWrite_out,
  output logic              MemtoReg_out,
  output logic              HALT_out,
  output logic [1:0]        wDataSrc_out,
  output logic [REG_W-1:0]  wsel_out,
  output logic [WORD_W-1:0] aluout_out,
  output logic [WORD_W-1:0] pcp4_out,
  output logic [WORD_W-1:0] memdata_out
);
  logic              r_dren, r_dwen, r_datomic, r_done, r_link_valid;
  logic [WORD_W-1:0] r_link_addr;
  logic              w_sc_fail, w_adv, w_snoop, w_ll_done, w_sc_done, w_st_hit;

  assign w_sc_fail = r_datomic & r_dwen & ~(r_link_valid & (r_link_addr == aluout_out));
  assign dmemREN   = r_dren & ~r_done;
  assign dmemWEN   = r_dwen & ~r_done & ~w_sc_fail;
  assign mem_stall = (dmemREN | dmemWEN) & ~dhit;
  assign w_adv     = ihit & ~mem_stall;
  assign dmemaddr  = aluout_out;
  assign w_snoop   = ccinv & (ccsnoopaddr == r_link_addr);
  assign w_ll_done = r_datomic & dmemREN & dhit;
  assign w_sc_done = r_datomic & ((dmemWEN & dhit) | (w_sc_fail & ~r_done));
  assign w_st_hit  = ~r_datomic & dmemWEN & dhit & (aluout_out == r_link_addr);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dren       <= 1'b0;
      r_dwen       <= 1'b0;
      r_datomic    <= 1'b0;
      r_done       <= 1'b0;
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
      regWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
      HALT_out     <= 1'b0;
      wDataSrc_out <= '0;
      wsel_out     <= '0;
      aluout_out   <= '0;
      pcp4_out     <= '0;
      dmemstore    <= '0;
      memdata_out  <= '0;
    end else begin
      if (w_adv) begin
        r_dren       <= ~flush & dREN_in;
        r_dwen       <= ~flush & dWEN_in;
        r_datomic    <= ~flush & datomic_in;
        regWrite_out <= ~flush & regWrite_in;
        MemtoReg_out <= ~flush & MemtoReg_in;
        HALT_out     <= ~flush & HALT_in;
        wDataSrc_out <= flush ? '0 : wDataSrc_in;
        wsel_out     <= flush ? '0 : wsel_in;
        aluout_out   <= flush ? '0 : aluout_in;
        pcp4_out     <= flush ? '0 : pcp4_in;
        dmemstore    <= flush ? '0 : store_in;
      end
      r_done <= w_adv ? 1'b0 : (r_done | (dhit & (dmemREN | dmemWEN)));
      // A snoop landing with the SC's dhit still reports failure.
      if (dhit & dmemREN)
        memdata_out <= dmemload;
      else if (dhit & dmemWEN & r_datomic)
        memdata_out <= {{(WORD_W-1){1'b0}}, ~w_snoop};
      else if (w_sc_fail & ~r_done)
        memdata_out <= '0;
      if (w_sc_done | w_st_hit | w_snoop)
        r_link_valid <= 1'b0;
      if (w_ll_done) begin
        r_link_valid <= 1'b1;
        r_link_addr  <= aluout_out;
      end
    end
  end
endmodule
